// File: rtl/ahb_matrix_if.sv
//------------------------------------------------------------------------------
// ahb_matrix_if : master-side and slave-side signal bundle of the AHB matrix
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_matrix_if #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 4
);
  logic [31:0] s_mhaddr_i      [MASTERS];
  logic [1:0]  s_mhtrans_i     [MASTERS];
  logic        s_mhwrite_i     [MASTERS];
  logic [2:0]  s_mhsize_i      [MASTERS];
  logic [31:0] s_mhwdata_i     [MASTERS];
  logic [31:0] s_mhrdata_o     [MASTERS];
  logic [6:0]  s_mhrchecksum_o [MASTERS];
  logic        s_mhready_o     [MASTERS];
  logic        s_mhresp_o      [MASTERS];

  logic [31:0] s_sbase_i       [SLAVES];
  logic [31:0] s_smask_i       [SLAVES];
  logic [31:0] s_shaddr_o      [SLAVES];
  logic [1:0]  s_shtrans_o     [SLAVES];
  logic        s_shwrite_o     [SLAVES];
  logic [2:0]  s_shsize_o      [SLAVES];
  logic [31:0] s_shwdata_o     [SLAVES];
  logic        s_hsel_o        [SLAVES];
  logic [31:0] s_shrdata_i     [SLAVES];
  logic [6:0]  s_shrchecksum_i [SLAVES];
  logic        s_shready_i     [SLAVES];
  logic        s_shresp_i      [SLAVES];

  modport master (
    input  s_mhaddr_i, s_mhtrans_i, s_mhwrite_i, s_mhsize_i, s_mhwdata_i,
    output s_mhrdata_o, s_mhrchecksum_o, s_mhready_o, s_mhresp_o
  );

  modport slave (
    input  s_sbase_i, s_smask_i, s_shrdata_i, s_shrchecksum_i, s_shready_i, s_shresp_i,
    output s_shaddr_o, s_shtrans_o, s_shwrite_o, s_shsize_o, s_shwdata_o, s_hsel_o
  );
endinterface

`default_nettype wire

// File: rtl/ahb_matrix.sv
//------------------------------------------------------------------------------
// ahb_matrix : multi-master AHB3-Lite interconnect, round-robin per slave
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ahb_matrix #(
  parameter int MASTERS = 2,
  parameter int SLAVES  = 4
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  ahb_matrix_if.master  mst,
  ahb_matrix_if.slave   slv
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES  > 1) ? $clog2(SLAVES)  : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } mst_state_t;

  mst_state_t    r_state  [MASTERS];
  mst_state_t    w_nxt    [MASTERS];
  logic [31:0]   r_haddr  [MASTERS];
  logic          r_hwrite [MASTERS];
  logic [2:0]    r_hsize  [MASTERS];
  logic [SW-1:0] r_tgt    [MASTERS];
  logic          w_accept [MASTERS];
  logic          w_hit    [MASTERS];
  logic [SW-1:0] w_dec    [MASTERS];
  logic          w_granted[MASTERS];

  logic          r_own_v  [SLAVES];
  logic [MW-1:0] r_own_m  [SLAVES];
  logic [MW-1:0] r_rr     [SLAVES];
  logic          w_gnt_v  [SLAVES];
  logic [MW-1:0] w_gnt_m  [SLAVES];
  logic [31:0]   r_saddr  [SLAVES];
  logic          r_swrite [SLAVES];
  logic [2:0]    r_ssize  [SLAVES];

  // Descending scan so the lowest matching slave index is the one kept.
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      w_hit[m] = 1'b0;
      w_dec[m] = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((mst.s_mhaddr_i[m] & slv.s_smask_i[s]) == slv.s_sbase_i[s]) begin
          w_hit[m] = 1'b1;
          w_dec[m] = SW'(s);
        end
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int s = 0; s < SLAVES; s++) begin
      w_gnt_v[s] = 1'b0;
      w_gnt_m[s] = '0;
      if (!r_own_v[s] || slv.s_shready_i[s]) begin
        for (int k = MASTERS - 1; k >= 0; k--) begin
          idx = int'(r_rr[s]) + k;
          if (idx >= MASTERS) idx = idx - MASTERS;
          if (r_state[idx] == ST_PEND && r_tgt[idx] == SW'(s)) begin
            w_gnt_v[s] = 1'b1;
            w_gnt_m[s] = MW'(idx);
          end
        end
      end
    end
    for (int m = 0; m < MASTERS; m++) begin
      w_granted[m] = 1'b0;
      for (int s = 0; s < SLAVES; s++) begin
        if (w_gnt_v[s] && w_gnt_m[s] == MW'(m)) w_granted[m] = 1'b1;
      end
    end
  end

  // Unmapped transfers skip PEND so the ERROR response starts one cycle after acceptance.
  always_comb begin
    logic rdy;
    for (int m = 0; m < MASTERS; m++) begin
      w_nxt[m]                  = r_state[m];
      rdy                       = 1'b1;
      mst.s_mhresp_o[m]         = 1'b0;
      mst.s_mhrdata_o[m]        = '0;
      mst.s_mhrchecksum_o[m]    = '0;
      case (r_state[m])
        ST_PEND: begin
          rdy = 1'b0;
          if (w_granted[m]) w_nxt[m] = ST_DATA;
        end
        ST_DATA: begin
          rdy                    = slv.s_shready_i[r_tgt[m]];
          mst.s_mhresp_o[m]      = slv.s_shresp_i[r_tgt[m]];
          mst.s_mhrdata_o[m]     = slv.s_shrdata_i[r_tgt[m]];
          mst.s_mhrchecksum_o[m] = slv.s_shrchecksum_i[r_tgt[m]];
          if (rdy) w_nxt[m] = ST_IDLE;
        end
        ST_ERR1: begin
          rdy               = 1'b0;
          mst.s_mhresp_o[m] = 1'b1;
          w_nxt[m]          = ST_ERR2;
        end
        ST_ERR2: begin
          mst.s_mhresp_o[m] = 1'b1;
          w_nxt[m]          = ST_IDLE;
        end
        default: ;
      endcase
      mst.s_mhready_o[m] = rdy;
      w_accept[m] = rdy && (mst.s_mhtrans_i[m] inside {2'b10, 2'b11});
      if (w_accept[m]) w_nxt[m] = w_hit[m] ? ST_PEND : ST_ERR1;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int m = 0; m < MASTERS; m++) begin
        r_state[m]  <= ST_IDLE;
        r_haddr[m]  <= '0;
        r_hwrite[m] <= 1'b0;
        r_hsize[m]  <= '0;
        r_tgt[m]    <= '0;
      end
    end else begin
      for (int m = 0; m < MASTERS; m++) begin
        r_state[m] <= w_nxt[m];
        if (w_accept[m]) begin
          r_haddr[m]  <= mst.s_mhaddr_i[m];
          r_hwrite[m] <= mst.s_mhwrite_i[m];
          r_hsize[m]  <= mst.s_mhsize_i[m];
          r_tgt[m]    <= w_dec[m];
        end
      end
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int s = 0; s < SLAVES; s++) begin
        r_own_v[s]  <= 1'b0;
        r_own_m[s]  <= '0;
        r_rr[s]     <= '0;
        r_saddr[s]  <= '0;
        r_swrite[s] <= 1'b0;
        r_ssize[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < SLAVES; s++) begin
        if (w_gnt_v[s]) begin
          r_own_v[s]  <= 1'b1;
          r_own_m[s]  <= w_gnt_m[s];
          r_rr[s]     <= (int'(w_gnt_m[s]) == MASTERS - 1) ? '0 : w_gnt_m[s] + 1'b1;
          r_saddr[s]  <= r_haddr[w_gnt_m[s]];
          r_swrite[s] <= r_hwrite[w_gnt_m[s]];
          r_ssize[s]  <= r_hsize[w_gnt_m[s]];
        end else if (slv.s_shready_i[s]) begin
          r_own_v[s] <= 1'b0;
        end
      end
    end
  end

  // Address/control hold their last granted value outside the grant cycle.
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      slv.s_hsel_o[s]    = w_gnt_v[s];
      slv.s_shtrans_o[s] = w_gnt_v[s] ? 2'b10 : 2'b00;
      slv.s_shaddr_o[s]  = w_gnt_v[s] ? r_haddr[w_gnt_m[s]]  : r_saddr[s];
      slv.s_shwrite_o[s] = w_gnt_v[s] ? r_hwrite[w_gnt_m[s]] : r_swrite[s];
      slv.s_shsize_o[s]  = w_gnt_v[s] ? r_hsize[w_gnt_m[s]]  : r_ssize[s];
      slv.s_shwdata_o[s] = r_own_v[s] ? mst.s_mhwdata_i[r_own_m[s]] : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_matrix.sv
//------------------------------------------------------------------------------
// tb_ahb_matrix : directed self-checking bench for ahb_matrix (2 masters, 4 slaves)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_matrix;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ahb_matrix_if #(.MASTERS(2), .SLAVES(4)) bus ();

  ahb_matrix #(.MASTERS(2), .SLAVES(4)) u_dut (
    .s_clk_i    (clk),
    .s_resetn_i (rst_n),
    .mst        (bus),
    .slv        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input logic [31:0] addr, input logic wr);
    bus.s_mhtrans_i[m] = 2'b10;
    bus.s_mhaddr_i[m]  = addr;
    bus.s_mhwrite_i[m] = wr;
    bus.s_mhsize_i[m]  = 3'b010;
  endtask

  task automatic idle_m(input int m);
    bus.s_mhtrans_i[m] = 2'b00;
  endtask

  function automatic logic [3:0] hsel_vec();
    logic [3:0] v;
    for (int s = 0; s < 4; s++) v[s] = bus.s_hsel_o[s];
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      bus.s_mhtrans_i[m] = 2'b00;
      bus.s_mhaddr_i[m]  = '0;
      bus.s_mhwrite_i[m] = 1'b0;
      bus.s_mhsize_i[m]  = 3'b010;
      bus.s_mhwdata_i[m] = '0;
    end
    for (int s = 0; s < 4; s++) begin
      bus.s_sbase_i[s]       = {16'(s), 16'h0000};
      bus.s_smask_i[s]       = 32'hFFFF_0000;
      bus.s_shrdata_i[s]     = '0;
      bus.s_shrchecksum_i[s] = '0;
      bus.s_shready_i[s]     = 1'b1;
      bus.s_shresp_i[s]      = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready0", 32'(bus.s_mhready_o[0]), 32'd1);
    check_val("rst_resp0",  32'(bus.s_mhresp_o[0]),  32'd0);
    check_val("rst_hsel",   32'(hsel_vec()),         32'd0);
    check_val("rst_trans0", 32'(bus.s_shtrans_o[0]), 32'd0);
    check_val("rst_addr0",  bus.s_shaddr_o[0],       32'd0);
    rst_n = 1'b1;

    // single zero-wait read M0 -> slave 0
    cyc(); issue(0, 32'h0000_0010, 1'b0); #1;
    check_val("rd_ready_T", 32'(bus.s_mhready_o[0]), 32'd1);
    cyc(); idle_m(0); #1;
    check_val("rd_hsel_T1",  32'(hsel_vec()),         32'h1);
    check_val("rd_trans_T1", 32'(bus.s_shtrans_o[0]), 32'd2);
    check_val("rd_addr_T1",  bus.s_shaddr_o[0],       32'h0000_0010);
    check_val("rd_ready_T1", 32'(bus.s_mhready_o[0]), 32'd0);
    cyc(); bus.s_shrdata_i[0] = 32'hA5A5_0001; bus.s_shrchecksum_i[0] = 7'h3C; #1;
    check_val("rd_ready_T2", 32'(bus.s_mhready_o[0]),     32'd1);
    check_val("rd_data_T2",  bus.s_mhrdata_o[0],          32'hA5A5_0001);
    check_val("rd_csum_T2",  32'(bus.s_mhrchecksum_o[0]), 32'h3C);
    cyc(); bus.s_shrdata_i[0] = '0; bus.s_shrchecksum_i[0] = '0; #1;
    check_val("rd_data_T3",  bus.s_mhrdata_o[0], 32'd0);

    // contention on slave 1: M0 first, then M1
    cyc(); issue(0, 32'h0001_0004, 1'b0); issue(1, 32'h0001_0008, 1'b0); #1;
    cyc(); idle_m(0); idle_m(1); #1;
    check_val("ct_addr_T1",   bus.s_shaddr_o[1],       32'h0001_0004);
    check_val("ct_ready1_T1", 32'(bus.s_mhready_o[1]), 32'd0);
    cyc(); #1;
    check_val("ct_hsel_T2",   32'(hsel_vec()),         32'h2);
    check_val("ct_addr_T2",   bus.s_shaddr_o[1],       32'h0001_0008);
    check_val("ct_ready0_T2", 32'(bus.s_mhready_o[0]), 32'd1);
    check_val("ct_ready1_T2", 32'(bus.s_mhready_o[1]), 32'd0);
    cyc(); #1;
    check_val("ct_ready1_T3", 32'(bus.s_mhready_o[1]), 32'd1);
    check_val("ct_hsel_T3",   32'(hsel_vec()),         32'h0);

    // solo M0 on slave 1 moves the pointer to M1, then both contend again
    cyc(); issue(0, 32'h0001_0010, 1'b0); #1;
    cyc(); idle_m(0); #1;
    check_val("solo_addr",    bus.s_shaddr_o[1],       32'h0001_0010);
    cyc(); #1;
    cyc(); issue(0, 32'h0001_0020, 1'b0); issue(1, 32'h0001_0024, 1'b0); #1;
    cyc(); idle_m(0); idle_m(1); #1;
    check_val("rr_first",     bus.s_shaddr_o[1],       32'h0001_0024);
    cyc(); #1;
    check_val("rr_second",    bus.s_shaddr_o[1],       32'h0001_0020);
    check_val("rr_ready1",    32'(bus.s_mhready_o[1]), 32'd1);
    cyc(); #1;
    check_val("rr_ready0",    32'(bus.s_mhready_o[0]), 32'd1);

    // parallel M0 -> slave 0, M1 -> slave 2
    cyc(); issue(0, 32'h0000_0020, 1'b0); issue(1, 32'h0002_0030, 1'b0); #1;
    cyc(); idle_m(0); idle_m(1); #1;
    check_val("par_hsel_T1",  32'(hsel_vec()),         32'h5);
    check_val("par_addr2",    bus.s_shaddr_o[2],       32'h0002_0030);
    cyc(); #1;
    check_val("par_ready0",   32'(bus.s_mhready_o[0]), 32'd1);
    check_val("par_ready1",   32'(bus.s_mhready_o[1]), 32'd1);

    // unmapped address on M1
    cyc(); issue(1, 32'hDEAD_0000, 1'b0); #1;
    cyc(); idle_m(1); #1;
    check_val("def_hsel_T1",  32'(hsel_vec()),         32'h0);
    check_val("def_resp_T1",  32'(bus.s_mhresp_o[1]),  32'd1);
    check_val("def_ready_T1", 32'(bus.s_mhready_o[1]), 32'd0);
    cyc(); #1;
    check_val("def_resp_T2",  32'(bus.s_mhresp_o[1]),  32'd1);
    check_val("def_ready_T2", 32'(bus.s_mhready_o[1]), 32'd1);
    check_val("def_hsel_T2",  32'(hsel_vec()),         32'h0);
    cyc(); #1;
    check_val("def_resp_T3",  32'(bus.s_mhresp_o[1]),  32'd0);

    // write to slave 3 with three wait states
    cyc(); issue(0, 32'h0003_0000, 1'b1); #1;
    cyc(); idle_m(0); bus.s_mhwdata_i[0] = 32'h1234_5678; #1;
    check_val("wr_hsel_T1",   32'(hsel_vec()),         32'h8);
    check_val("wr_write_T1",  32'(bus.s_shwrite_o[3]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.s_shready_i[3] = 1'b0; #1;
      check_val("wr_wdata_wait", bus.s_shwdata_o[3],       32'h1234_5678);
      check_val("wr_ready_wait", 32'(bus.s_mhready_o[0]),  32'd0);
    end
    cyc(); bus.s_shready_i[3] = 1'b1; #1;
    check_val("wr_wdata_T5",  bus.s_shwdata_o[3],       32'h1234_5678);
    check_val("wr_ready_T5",  32'(bus.s_mhready_o[0]),  32'd1);
    cyc(); bus.s_mhwdata_i[0] = '0; #1;
    check_val("wr_wdata_T6",  bus.s_shwdata_o[3],       32'd0);

    // asynchronous reset during a data phase
    cyc(); issue(0, 32'h0003_0040, 1'b0); #1;
    cyc(); idle_m(0); bus.s_mhwdata_i[0] = 32'hCAFE_0001; #1;
    cyc(); bus.s_shready_i[3] = 1'b0; bus.s_shrdata_i[3] = 32'h5555_AAAA; #1;
    check_val("ar_data_pre",  bus.s_mhrdata_o[0],       32'h5555_AAAA);
    check_val("ar_wdata_pre", bus.s_shwdata_o[3],       32'hCAFE_0001);
    #1 rst_n = 1'b0;
    #1;
    check_val("ar_ready",     32'(bus.s_mhready_o[0]),  32'd1);
    check_val("ar_resp",      32'(bus.s_mhresp_o[0]),   32'd0);
    check_val("ar_rdata",     bus.s_mhrdata_o[0],       32'd0);
    check_val("ar_addr3",     bus.s_shaddr_o[3],        32'd0);
    check_val("ar_wdata3",    bus.s_shwdata_o[3],       32'd0);
    cyc(); rst_n = 1'b1; bus.s_shready_i[3] = 1'b1; bus.s_shrdata_i[3] = '0; bus.s_mhwdata_i[0] = '0; #1;
    cyc(); issue(0, 32'h0003_0080, 1'b0); #1;
    check_val("ar_post_rdyT", 32'(bus.s_mhready_o[0]),  32'd1);
    cyc(); idle_m(0); #1;
    check_val("ar_post_hsel", 32'(hsel_vec()),          32'h8);
    check_val("ar_post_addr", bus.s_shaddr_o[3],        32'h0003_0080);
    cyc(); #1;
    check_val("ar_post_rdy2", 32'(bus.s_mhready_o[0]),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
